// File: rtl/seq_chunk_comparator_pkg.sv
// Shared types for the sequential chunk comparator: FSM states and the
// one-hot {less_than, equal_to, greater_than} result encoding.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

endpackage

// File: rtl/seq_chunk_comparator_if.sv
// Operand/result handshake bundle for seq_chunk_comparator.
// The master side is the producer/consumer; the slave side is the comparator.
interface seq_chunk_comparator_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             less_than;
    logic             equal_to;
    logic             greater_than;
    logic [CW-1:0]    cycles;

    modport master (
        output in_valid, a_in, b_in, signed_mode, out_ready,
        input  in_ready, out_valid, less_than, equal_to, greater_than, cycles
    );

    modport slave (
        input  in_valid, a_in, b_in, signed_mode, out_ready,
        output in_ready, out_valid, less_than, equal_to, greater_than, cycles
    );

endinterface

// File: rtl/seq_chunk_comparator_chunk.sv
// Combinational magnitude compare of one CHUNK-bit slice. msb_invert flips the
// top bit of both inputs so the top chunk of a signed operand orders correctly.
module comparator_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             msb_invert,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    logic [CHUNK-1:0] mask;
    logic [CHUNK-1:0] a_x;
    logic [CHUNK-1:0] b_x;

    always_comb begin
        mask            = '0;
        mask[CHUNK-1]   = msb_invert;
        a_x             = a ^ mask;
        b_x             = b ^ mask;
        lt              = (a_x < b_x);
        eq              = (a_x == b_x);
        gt              = (a_x > b_x);
    end

endmodule

// File: rtl/seq_chunk_comparator.sv
// Compares two WIDTH-bit operands one CHUNK at a time from the top, stopping at
// the first differing chunk; returns a registered one-hot LT/EQ/GT and a cycle count.
module seq_chunk_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_chunk_comparator_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH) + 1;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cycles_q, cycles_d;
    logic [2:0]       res_q, res_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             msb_invert;
    logic             c_lt, c_eq, c_gt;

    // Only the top chunk carries the sign bit.
    assign a_chunk    = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign b_chunk    = b_q[int'(idx_q)*CHUNK +: CHUNK];
    assign msb_invert = signed_q && (idx_q == IW'(NCH - 1));

    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a          (a_chunk),
        .b          (b_chunk),
        .msb_invert (msb_invert),
        .lt         (c_lt),
        .eq         (c_eq),
        .gt         (c_gt)
    );

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        cycles_d = cycles_q;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a_in;
                    b_d      = bus.b_in;
                    signed_d = bus.signed_mode;
                    idx_d    = IW'(NCH - 1);
                    cycles_d = '0;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                cycles_d = cycles_q + CW'(1);
                if (!c_eq) begin
                    res_d   = c_lt ? LT : GT;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            cycles_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            cycles_q <= cycles_d;
            res_q    <= res_d;
        end
    end

    // Handshake flags are pure state decodes; reset only masks the accept window.
    assign bus.in_ready     = (state_q == IDLE) && !reset;
    assign bus.out_valid    = (state_q == DONE);
    assign bus.less_than    = res_q[2];
    assign bus.equal_to     = res_q[1];
    assign bus.greater_than = res_q[0];
    assign bus.cycles       = cycles_q;

    logic unused_c_gt;
    assign unused_c_gt = c_gt;

endmodule

// File: tb/tb_seq_chunk_comparator.sv
// Directed self-checking bench for seq_chunk_comparator (WIDTH=32, CHUNK=8),
// plus a short batch of random operands against an independent reference model.
module tb_seq_chunk_comparator;
    import seq_cmp_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    seq_chunk_comparator_if #(.WIDTH(32), .CHUNK(8)) bus ();

    seq_chunk_comparator #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] res_now();
        return {bus.less_than, bus.equal_to, bus.greater_than};
    endfunction

    function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) begin
            if ($signed(a) < $signed(b)) return 3'b100;
            if ($signed(a) > $signed(b)) return 3'b001;
        end else begin
            if (a < b) return 3'b100;
            if (a > b) return 3'b001;
        end
        return 3'b010;
    endfunction

    function automatic int ref_cycles(input logic [31:0] a, input logic [31:0] b);
        for (int i = 3; i >= 0; i--)
            if (a[i*8 +: 8] != b[i*8 +: 8]) return 4 - i;
        return 4;
    endfunction

    // Accept at a posedge, wait for out_valid, check latency/result, then consume.
    task automatic run_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [2:0] exp_res, input int exp_cyc);
        int lat;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a_in = a;  bus.b_in = b;  bus.signed_mode = s;  bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_cyc));
        check({tag, ".result"}, 32'(res_now()), 32'(exp_res));
        check({tag, ".cycles"}, 32'(bus.cycles), 32'(exp_cyc));
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check({tag, ".idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, ".valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".result_hold"}, 32'(res_now()), 32'(exp_res));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          lat;

        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
        bus.a_in = '0;  bus.b_in = '0;  bus.signed_mode = 1'b0;

        repeat (3) @(negedge clock);
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.result", 32'(res_now()), 32'd0);
        check("rst.cycles", 32'(bus.cycles), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_cmp("early_gt",   32'h1200_0000, 32'h11FF_FFFF, 1'b0, GT, 1);
        run_cmp("full_eq",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, EQ, 4);
        run_cmp("full_lt",    32'hDEAD_BEEE, 32'hDEAD_BEEF, 1'b0, LT, 4);
        run_cmp("signed_lt",  32'h8000_0000, 32'h0000_0001, 1'b1, LT, 1);
        run_cmp("unsig_gt",   32'h8000_0000, 32'h0000_0001, 1'b0, GT, 1);
        run_cmp("signed_gt4", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, GT, 4);
        run_cmp("chunk2_lt",  32'h7F12_0000, 32'h7F13_0000, 1'b1, LT, 2);
        run_cmp("chunk3_gt",  32'h0000_8000, 32'h0000_7F00, 1'b1, GT, 3);

        // Backpressure: hold the result in DONE while a new offer is presented.
        bus.a_in = 32'h0100_0000;  bus.b_in = 32'h0200_0000;  bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.a_in = 32'hFFFF_FFFF;  bus.b_in = 32'h0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("bp.latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp.result", 32'(res_now()), 32'(LT));
            check("bp.cycles", 32'(bus.cycles), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("bp.release_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp.release_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the second EVAL cycle discards the operation.
        bus.a_in = 32'h0;  bus.b_in = 32'h1;  bus.signed_mode = 1'b0;  bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst.result", 32'(res_now()), 32'd0);
        check("mid_rst.cycles", 32'(bus.cycles), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        run_cmp("after_rst", 32'h0, 32'h1, 1'b0, LT, 4);

        // Random operands against the reference model; small byte alphabet forces deep compares.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h5A;
                rb[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h5A;
            end
            if ($urandom_range(0, 1) == 1) ra[31] = ~ra[31];
            rs = 1'($urandom);
            run_cmp("rand", ra, rb, rs, ref_res(ra, rb, rs), ref_cycles(ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
